imm_ext_unit: RTL

IMM_EXT_UNIT -- requirements
Module: imm_ext_unit

---
 rtl/ext_pkg.sv | 20 ++
 rtl/ext_core.sv | 40 ++++
 rtl/imm_ext_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/ext_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ext_pkg : extension-mode encodings shared by the decoder and its users.
// Rev 1.0
// ---------------------------------------------------------------------------
package ext_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_SEXT = 3'd0;
  localparam logic [MODE_W-1:0] MODE_ZEXT = 3'd1;
  localparam logic [MODE_W-1:0] MODE_LUI  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BOFS = 3'd3;
  localparam logic [MODE_W-1:0] MODE_LB   = 3'd4;
  localparam logic [MODE_W-1:0] MODE_LBU  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_LH   = 3'd6;
  localparam logic [MODE_W-1:0] MODE_LHU  = 3'd7;

endpackage : ext_pkg
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ext_core : stateless immediate extension, IN_W -> OUT_W by mode.
// Rev 1.0
// ---------------------------------------------------------------------------
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   imm,
  input  logic [MODE_W-1:0] mode,
  output logic [OUT_W-1:0]  ext
);

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] bofs_val;

  assign sext_val = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  // Top two bits of the sign-extended value fall off; no overflow flag.
  assign bofs_val = {sext_val[OUT_W-3:0], 2'b00};

  always_comb begin
    ext = sext_val;
    case (mode)
      MODE_SEXT: ext = sext_val;
      MODE_ZEXT: ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_LUI:  ext = {imm[15:0], {(OUT_W-16){1'b0}}};
      MODE_BOFS: ext = bofs_val;
      MODE_LB:   ext = {{(OUT_W-8){imm[7]}}, imm[7:0]};
      MODE_LBU:  ext = {{(OUT_W-8){1'b0}}, imm[7:0]};
      MODE_LH:   ext = {{(OUT_W-16){imm[15]}}, imm[15:0]};
      MODE_LHU:  ext = {{(OUT_W-16){1'b0}}, imm[15:0]};
      default:   ext = sext_val;
    endcase
  end

endmodule : ext_core
`default_nettype wire

// File: rtl/imm_ext_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm_ext_unit : registered immediate extender with output + skid buffer.
// Rev 1.0
// ---------------------------------------------------------------------------
module imm_ext_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_imm,
  output logic [TAG_W-1:0]  out_tag
);

  logic [OUT_W-1:0] ext_val;
  logic             accept;

  logic             out_valid_q,  out_valid_d;
  logic [OUT_W-1:0] out_imm_q,    out_imm_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             in_ready_q,   in_ready_d;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext_val)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low whenever SKID holds an item, so no accept here.
      if (out_ready || !out_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_val;
        out_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = ext_val;
        skid_tag_d   = in_tag;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign out_tag   = out_tag_q;

endmodule : imm_ext_unit
`default_nettype wire
